// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the RAM-side port of ram_arbiter.
// The master modport is the arbiter side. The slave modport is the
// environment side: requesters plus the RAM.
interface ram_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    logic          ram_wr_enb;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_data_in;
    logic          ram_rd_enb;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_data_out;

    logic          busy;

    modport master (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_wr_enb, ram_wr_addr, ram_data_in,
        output ram_rd_enb, ram_rd_addr,
        input  ram_data_out,
        output busy
    );

    modport slave (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_wr_enb, ram_wr_addr, ram_data_in,
        input  ram_rd_enb, ram_rd_addr,
        output ram_data_out,
        input  busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer that shares one RAM between requesters A and B.
// One command is in flight at a time: IDLE -> ISSUE -> (write) IDLE,
// or IDLE -> ISSUE -> WAIT x RD_LAT -> RESP -> IDLE for a read.
module ram_arbiter #(
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    ram_arbiter_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    logic [1:0]    state;
    logic          last_win;   // 1 = B won most recently
    logic          win;        // 1 = B owns the command in flight
    logic          cmd_we;
    logic [1:0]    wait_cnt;
    logic [AW-1:0] wr_addr_q;
    logic [AW-1:0] rd_addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;
    logic          pick_b;

    // Winner selection: a lone requester wins, and on a tie the one that did not win last time wins.
    always_comb begin
        pick_b = bus.b_req && (!bus.a_req || !last_win);
    end

    // Sequencer: arbitrate in IDLE, register the command, then step through issue/wait/response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_win  <= 1'b1;
            win       <= 1'b0;
            cmd_we    <= 1'b0;
            wait_cnt  <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.a_req || bus.b_req) begin
                        win      <= pick_b;
                        last_win <= pick_b;
                        cmd_we   <= pick_b ? bus.b_we : bus.a_we;
                        if (pick_b ? bus.b_we : bus.a_we) begin
                            wr_addr_q <= pick_b ? bus.b_addr  : bus.a_addr;
                            wdata_q   <= pick_b ? bus.b_wdata : bus.a_wdata;
                        end else begin
                            rd_addr_q <= pick_b ? bus.b_addr : bus.a_addr;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= cmd_we ? IDLE : WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (win) b_rdata_q <= bus.ram_data_out;
                        else     a_rdata_q <= bus.ram_data_out;
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_gnt       = (state == ISSUE) && !win;
    assign bus.b_gnt       = (state == ISSUE) &&  win;
    assign bus.ram_wr_enb  = (state == ISSUE) &&  cmd_we;
    assign bus.ram_rd_enb  = (state == ISSUE) && !cmd_we;
    assign bus.ram_wr_addr = wr_addr_q;
    assign bus.ram_data_in = wdata_q;
    assign bus.ram_rd_addr = rd_addr_q;
    assign bus.a_rvalid    = (state == RESP) && !win;
    assign bus.b_rvalid    = (state == RESP) &&  win;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one RD_LAT=1 instance for the main tests and one
// RD_LAT=2 instance for the latency test, each with its own behavioural RAM.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(4), .DW(8)) bus1 ();
    ram_arbiter_if #(.AW(4), .DW(8)) bus2 ();

    ram_arbiter #(.AW(4), .DW(8), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    ram_arbiter #(.AW(4), .DW(8), .RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // RAM behind dut1: one-cycle registered read
    logic [7:0] mem1 [16];
    logic [7:0] rd1_s1;
    assign bus1.ram_data_out = rd1_s1;
    always @(posedge clk) begin
        if (bus1.ram_wr_enb) mem1[bus1.ram_wr_addr] <= bus1.ram_data_in;
        if (bus1.ram_rd_enb) rd1_s1 <= mem1[bus1.ram_rd_addr];
    end

    // RAM behind dut2: two-cycle registered read
    logic [7:0] mem2 [16];
    logic [7:0] rd2_s1, rd2_s2;
    assign bus2.ram_data_out = rd2_s2;
    always @(posedge clk) begin
        if (bus2.ram_wr_enb) mem2[bus2.ram_wr_addr] <= bus2.ram_data_in;
        if (bus2.ram_rd_enb) rd2_s1 <= mem2[bus2.ram_rd_addr];
        rd2_s2 <= rd2_s1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero1(input string tag);
        chk1({tag, ".a_gnt"},     bus1.a_gnt,      1'b0);
        chk1({tag, ".b_gnt"},     bus1.b_gnt,      1'b0);
        chk1({tag, ".a_rvalid"},  bus1.a_rvalid,   1'b0);
        chk1({tag, ".b_rvalid"},  bus1.b_rvalid,   1'b0);
        chk8({tag, ".a_rdata"},   bus1.a_rdata,    8'h00);
        chk8({tag, ".b_rdata"},   bus1.b_rdata,    8'h00);
        chk1({tag, ".wr_enb"},    bus1.ram_wr_enb, 1'b0);
        chk1({tag, ".rd_enb"},    bus1.ram_rd_enb, 1'b0);
        chk4({tag, ".wr_addr"},   bus1.ram_wr_addr, 4'h0);
        chk4({tag, ".rd_addr"},   bus1.ram_rd_addr, 4'h0);
        chk8({tag, ".data_in"},   bus1.ram_data_in, 8'h00);
        chk1({tag, ".busy"},      bus1.busy,       1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus1.a_req = 1'b0; bus1.a_we = 1'b0; bus1.a_addr = 4'h0; bus1.a_wdata = 8'h00;
        bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_addr = 4'h0; bus1.b_wdata = 8'h00;
        bus2.a_req = 1'b0; bus2.a_we = 1'b0; bus2.a_addr = 4'h0; bus2.a_wdata = 8'h00;
        bus2.b_req = 1'b0; bus2.b_we = 1'b0; bus2.b_addr = 4'h0; bus2.b_wdata = 8'h00;

        // Test 1: reset state, then A writes A5 to address 0
        rst = 1'b1;
        tick(); tick();
        chk_zero1("t1_reset");
        rst = 1'b0;
        bus1.a_req = 1'b1; bus1.a_we = 1'b1; bus1.a_addr = 4'h0; bus1.a_wdata = 8'hA5;
        tick();
        chk1("t1_a_gnt",   bus1.a_gnt,       1'b1);
        chk1("t1_b_gnt",   bus1.b_gnt,       1'b0);
        chk1("t1_wr_enb",  bus1.ram_wr_enb,  1'b1);
        chk1("t1_rd_enb",  bus1.ram_rd_enb,  1'b0);
        chk4("t1_wr_addr", bus1.ram_wr_addr, 4'h0);
        chk8("t1_data_in", bus1.ram_data_in, 8'hA5);
        chk1("t1_busy",    bus1.busy,        1'b1);
        bus1.a_req = 1'b0;
        tick();
        chk1("t1_wr_off",  bus1.ram_wr_enb,  1'b0);
        chk1("t1_idle",    bus1.busy,        1'b0);
        chk8("t1_hold",    bus1.ram_data_in, 8'hA5);

        // Test 2: A reads address 0, response at N+3
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 4'h0;
        tick();
        chk1("t2_a_gnt",   bus1.a_gnt,       1'b1);
        chk1("t2_rd_enb",  bus1.ram_rd_enb,  1'b1);
        chk1("t2_wr_enb",  bus1.ram_wr_enb,  1'b0);
        chk4("t2_rd_addr", bus1.ram_rd_addr, 4'h0);
        bus1.a_req = 1'b0;
        tick();
        chk1("t2_wait_rv", bus1.a_rvalid,    1'b0);
        chk1("t2_wait_bz", bus1.busy,        1'b1);
        tick();
        chk1("t2_a_rvalid", bus1.a_rvalid,   1'b1);
        chk8("t2_a_rdata",  bus1.a_rdata,    8'hA5);
        chk1("t2_b_rvalid", bus1.b_rvalid,   1'b0);
        tick();
        chk1("t2_rv_off",   bus1.a_rvalid,   1'b0);
        chk1("t2_idle",     bus1.busy,       1'b0);
        chk8("t2_rd_hold",  bus1.a_rdata,    8'hA5);

        // Test 3: simultaneous writes from reset, then simultaneous reads
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        bus1.a_req = 1'b1; bus1.a_we = 1'b1; bus1.a_addr = 4'h1; bus1.a_wdata = 8'h3C;
        bus1.b_req = 1'b1; bus1.b_we = 1'b1; bus1.b_addr = 4'h2; bus1.b_wdata = 8'h7E;
        tick();
        chk1("t3_w_a_gnt", bus1.a_gnt,       1'b1);
        chk1("t3_w_b_no",  bus1.b_gnt,       1'b0);
        chk4("t3_w_addrA", bus1.ram_wr_addr, 4'h1);
        chk8("t3_w_dataA", bus1.ram_data_in, 8'h3C);
        bus1.a_req = 1'b0;
        tick();
        chk1("t3_w_gap",   bus1.b_gnt,       1'b0);
        tick();
        chk1("t3_w_b_gnt", bus1.b_gnt,       1'b1);
        chk1("t3_w_a_no",  bus1.a_gnt,       1'b0);
        chk4("t3_w_addrB", bus1.ram_wr_addr, 4'h2);
        chk8("t3_w_dataB", bus1.ram_data_in, 8'h7E);
        bus1.b_req = 1'b0;
        tick();
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 4'h1;
        bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = 4'h2;
        tick();
        chk1("t3_r_a_gnt", bus1.a_gnt,       1'b1);
        chk1("t3_r_b_no",  bus1.b_gnt,       1'b0);
        chk4("t3_r_addrA", bus1.ram_rd_addr, 4'h1);
        bus1.a_req = 1'b0;
        tick();
        tick();
        chk1("t3_a_rvalid", bus1.a_rvalid,   1'b1);
        chk8("t3_a_rdata",  bus1.a_rdata,    8'h3C);
        chk1("t3_b_rv_no",  bus1.b_rvalid,   1'b0);
        tick();
        chk1("t3_r_gap",    bus1.b_gnt,      1'b0);
        tick();
        chk1("t3_r_b_gnt",  bus1.b_gnt,      1'b1);
        chk4("t3_r_addrB",  bus1.ram_rd_addr, 4'h2);
        bus1.b_req = 1'b0;
        tick();
        tick();
        chk1("t3_b_rvalid", bus1.b_rvalid,   1'b1);
        chk8("t3_b_rdata",  bus1.b_rdata,    8'h7E);
        chk1("t3_a_rv_no",  bus1.a_rvalid,   1'b0);
        chk8("t3_a_keep",   bus1.a_rdata,    8'h3C);
        tick();

        // Test 4: both hold req for 8 writes; grants alternate A,B,... starting with A
        bus1.a_req = 1'b1; bus1.a_we = 1'b1; bus1.a_addr = 4'h4; bus1.a_wdata = 8'h11;
        bus1.b_req = 1'b1; bus1.b_we = 1'b1; bus1.b_addr = 4'h5; bus1.b_wdata = 8'h22;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk1("t4_a_gnt",   bus1.a_gnt,   (i % 4) == 0);
            chk1("t4_b_gnt",   bus1.b_gnt,   (i % 4) == 2);
            chk1("t4_exclusive", bus1.a_gnt && bus1.b_gnt, 1'b0);
            if ((i % 4) == 0) chk4("t4_addrA", bus1.ram_wr_addr, 4'h4);
            if ((i % 4) == 2) chk4("t4_addrB", bus1.ram_wr_addr, 4'h5);
        end
        bus1.a_req = 1'b0; bus1.b_req = 1'b0;
        tick();
        chk1("t4_idle", bus1.busy, 1'b0);

        // Test 5: reset during WAIT of an A read, then B reads address 2
        bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = 4'h1;
        tick();
        chk1("t5_a_gnt", bus1.a_gnt, 1'b1);
        bus1.a_req = 1'b0;
        tick();
        chk1("t5_in_wait", bus1.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk_zero1("t5_async");
        tick();
        chk1("t5_no_rv0", bus1.a_rvalid, 1'b0);
        rst = 1'b0;
        tick();
        chk1("t5_no_rv1", bus1.a_rvalid, 1'b0);
        chk1("t5_idle",   bus1.busy,     1'b0);
        bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = 4'h2;
        tick();
        chk1("t5_b_gnt", bus1.b_gnt, 1'b1);
        bus1.b_req = 1'b0;
        tick();
        tick();
        chk1("t5_b_rvalid", bus1.b_rvalid, 1'b1);
        chk8("t5_b_rdata",  bus1.b_rdata,  8'h7E);
        chk1("t5_a_rv_no",  bus1.a_rvalid, 1'b0);
        tick();

        // Test 6: RD_LAT=2 instance, write 55 to address 3 then read it back
        bus2.a_req = 1'b1; bus2.a_we = 1'b1; bus2.a_addr = 4'h3; bus2.a_wdata = 8'h55;
        tick();
        chk1("t6_w_gnt",  bus2.a_gnt,      1'b1);
        chk1("t6_w_enb",  bus2.ram_wr_enb, 1'b1);
        bus2.a_req = 1'b0;
        tick();
        bus2.a_req = 1'b1; bus2.a_we = 1'b0; bus2.a_addr = 4'h3;
        tick();
        chk1("t6_r_gnt",   bus2.a_gnt,       1'b1);
        chk1("t6_r_enb",   bus2.ram_rd_enb,  1'b1);
        chk4("t6_r_addr",  bus2.ram_rd_addr, 4'h3);
        bus2.a_req = 1'b0;
        tick();
        chk1("t6_rv_n2",   bus2.a_rvalid, 1'b0);
        tick();
        chk1("t6_rv_n3",   bus2.a_rvalid, 1'b0);
        tick();
        chk1("t6_rvalid",  bus2.a_rvalid, 1'b1);
        chk8("t6_rdata",   bus2.a_rdata,  8'h55);
        tick();
        chk1("t6_rv_off",  bus2.a_rvalid, 1'b0);
        chk1("t6_idle",    bus2.busy,     1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
